// File: rtl/apmu_ibex_ex_sequencer.sv
// apmu_ibex_ex_sequencer
// ID-side sequencer for the EX stage. It issues decoded instructions into EX,
// drives the dynamic mult/div enables and the ALU first-cycle flag, holds the
// two 34-bit intermediate-value registers written by EX, runs a watchdog on
// multi-cycle operations and retires results to the register file one cycle
// after completion.
// Optional feature: define APMU_EX_SEQ_PERF_EN to build a saturating 32-bit
// EX stall-cycle counter on perf_stall_cnt_o; otherwise that output is tied to 0.
module apmu_ibex_ex_sequencer #(
  parameter int unsigned MaxCycles = 40  // legal range 2..63 (6-bit watchdog)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             instr_valid_i,
  input  logic             instr_kill_i,
  input  logic             mult_sel_i,
  input  logic             div_sel_i,
  input  logic             alu_multicycle_i,
  input  logic             wb_ready_i,
  input  logic             ex_valid_i,
  input  logic [31:0]      result_ex_i,
  input  logic [1:0]       imd_val_we_i,
  input  logic [1:0][33:0] imd_val_d_i,
  output logic [1:0][33:0] imd_val_q_o,
  output logic             mult_en_o,
  output logic             div_en_o,
  output logic             alu_instr_first_cycle_o,
  output logic             multdiv_ready_id_o,
  output logic             stall_o,
  output logic             rf_we_o,
  output logic [31:0]      rf_wdata_o,
  output logic             timeout_o,
  output logic [31:0]      perf_stall_cnt_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    MULTI = 1'b1
  } state_e;

  localparam logic [5:0] WdLast = 6'(MaxCycles - 1);

  state_e      state_reg;
  logic [5:0]  wd_reg;
  logic        rf_we_reg;
  logic [31:0] rf_wdata_reg;

  logic multi;
  logic done;
  logic first_cycle;
  logic mult_en;
  logic div_en;
  logic stall;
  logic md_ready;
  logic timeout;
  logic complete;
  logic go_multi;

  assign multi = mult_sel_i | div_sel_i | alu_multicycle_i;
  assign done  = ex_valid_i & wb_ready_i;

  // Issue/handshake decode; kill masks the enables and completion in the same
  // cycle, and everything reads 0 while reset is asserted.
  always_comb begin
    first_cycle = 1'b0;
    mult_en     = 1'b0;
    div_en      = 1'b0;
    stall       = 1'b0;
    md_ready    = 1'b0;
    timeout     = 1'b0;
    complete    = 1'b0;
    go_multi    = 1'b0;
    if (rst_ni) begin
      stall    = instr_valid_i & ~done & ~instr_kill_i;
      md_ready = wb_ready_i & ((state_reg == MULTI) | instr_valid_i);
      if (!instr_kill_i) begin
        case (state_reg)
          IDLE: begin
            if (instr_valid_i) begin
              first_cycle = 1'b1;
              mult_en     = mult_sel_i;
              div_en      = div_sel_i;
              complete    = done;
              go_multi    = multi & ~done;
            end
          end
          MULTI: begin
            mult_en  = mult_sel_i;
            div_en   = div_sel_i;
            complete = done;
            timeout  = ~done & (wd_reg == WdLast);
          end
          default: ;
        endcase
      end
    end
  end

  // Sequencer state and watchdog; kill always returns to IDLE with a cleared watchdog.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      wd_reg    <= '0;
    end else if (instr_kill_i) begin
      state_reg <= IDLE;
      wd_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          wd_reg <= '0;
          if (go_multi) state_reg <= MULTI;
        end
        MULTI: begin
          if (complete || timeout) begin
            state_reg <= IDLE;
            wd_reg    <= '0;
          end else begin
            wd_reg <= wd_reg + 6'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
          wd_reg    <= '0;
        end
      endcase
    end
  end

  // Retire: one-cycle write pulse; write data holds until the next completion.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rf_we_reg    <= 1'b0;
      rf_wdata_reg <= '0;
    end else begin
      rf_we_reg <= complete;
      if (complete) rf_wdata_reg <= result_ex_i;
    end
  end

  // Intermediate-value registers, written by EX in any state (including kill).
  for (genvar gi = 0; gi < 2; gi++) begin : g_imd
    logic [33:0] imd_reg;
    // Per-register write from the EX imd port.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        imd_reg <= '0;
      end else if (imd_val_we_i[gi]) begin
        imd_reg <= imd_val_d_i[gi];
      end
    end
    assign imd_val_q_o[gi] = imd_reg;
  end

`ifdef APMU_EX_SEQ_PERF_EN
  logic [31:0] perf_reg;
  // Saturating count of cycles in which ID is stalled.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      perf_reg <= '0;
    end else if (stall && (perf_reg != 32'hFFFF_FFFF)) begin
      perf_reg <= perf_reg + 32'd1;
    end
  end
  assign perf_stall_cnt_o = perf_reg;
`else
  assign perf_stall_cnt_o = '0;
`endif

  assign mult_en_o               = mult_en;
  assign div_en_o                = div_en;
  assign alu_instr_first_cycle_o = first_cycle;
  assign multdiv_ready_id_o      = md_ready;
  assign stall_o                 = stall;
  assign timeout_o               = timeout;
  assign rf_we_o                 = rf_we_reg;
  assign rf_wdata_o              = rf_wdata_reg;

endmodule

// File: tb/tb_apmu_ibex_ex_sequencer.sv
// Testbench for apmu_ibex_ex_sequencer: directed scenarios followed by random
// traffic, all checked against a transaction-level reference model.
module tb_apmu_ibex_ex_sequencer;

  localparam int MAX = 40;
`ifdef APMU_EX_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             valid, kill, msel, dsel, amc, wbr, exv;
  logic [31:0]      res;
  logic [1:0]       we;
  logic [1:0][33:0] d;
  logic [1:0][33:0] imd_q;
  logic             mult_en, div_en, first, md_rdy, stall, rf_we, tmo;
  logic [31:0]      rf_wdata, perf;

  apmu_ibex_ex_sequencer #(.MaxCycles(MAX)) dut (
    .clk_i                   (clk),
    .rst_ni                  (rst_n),
    .instr_valid_i           (valid),
    .instr_kill_i            (kill),
    .mult_sel_i              (msel),
    .div_sel_i               (dsel),
    .alu_multicycle_i        (amc),
    .wb_ready_i              (wbr),
    .ex_valid_i              (exv),
    .result_ex_i             (res),
    .imd_val_we_i            (we),
    .imd_val_d_i             (d),
    .imd_val_q_o             (imd_q),
    .mult_en_o               (mult_en),
    .div_en_o                (div_en),
    .alu_instr_first_cycle_o (first),
    .multdiv_ready_id_o      (md_rdy),
    .stall_o                 (stall),
    .rf_we_o                 (rf_we),
    .rf_wdata_o              (rf_wdata),
    .timeout_o               (tmo),
    .perf_stall_cnt_o        (perf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: "busy" means a multi-cycle instruction is waiting on EX,
  // "age" is how many cycles it has waited so far.
  bit               m_busy;
  int               m_age;
  logic             m_rfwe;
  logic [31:0]      m_wdata;
  logic [1:0][33:0] m_imd;
  logic [31:0]      m_perf;

  int n_pass, n_checks;
  int seen_mul, seen_stall, seen_to;
  logic o_first, o_div, o_mul, o_to;

  task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock: combinational outputs checked mid-cycle, registered ones after the edge.
  task automatic cycle();
    logic e_done, e_first, e_mul, e_div, e_stall, e_rdy, e_to, e_cmp, active;
    #3;
    e_done  = exv & wbr;
    active  = m_busy || valid;
    e_first = 1'b0; e_mul = 1'b0; e_div = 1'b0; e_stall = 1'b0;
    e_rdy   = 1'b0; e_to = 1'b0; e_cmp = 1'b0;
    if (rst_n) begin
      e_first = !m_busy && valid && !kill;
      e_mul   = !kill && msel && active;
      e_div   = !kill && dsel && active;
      e_stall = valid && !e_done && !kill;
      e_rdy   = wbr && active;
      e_to    = m_busy && !kill && !e_done && (m_age == MAX - 1);
      e_cmp   = !kill && e_done && active;
    end
    check("first_cycle", 68'(first), 68'(e_first));
    check("mult_en", 68'(mult_en), 68'(e_mul));
    check("div_en", 68'(div_en), 68'(e_div));
    check("stall", 68'(stall), 68'(e_stall));
    check("md_ready", 68'(md_rdy), 68'(e_rdy));
    check("timeout", 68'(tmo), 68'(e_to));
    o_first = first; o_div = div_en; o_mul = mult_en; o_to = tmo;
    if (mult_en) seen_mul++;
    if (stall) seen_stall++;
    if (tmo) seen_to++;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_busy = 0; m_age = 0; m_rfwe = 0; m_wdata = '0; m_imd = '0; m_perf = '0;
    end else begin
      m_rfwe = e_cmp;
      if (e_cmp) m_wdata = res;
      for (int k = 0; k < 2; k++) if (we[k]) m_imd[k] = d[k];
      if (e_stall && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 32'd1;
      if (kill) begin
        m_busy = 0; m_age = 0;
      end else if (m_busy) begin
        if (e_done || e_to) begin m_busy = 0; m_age = 0; end
        else m_age++;
      end else if (valid && (msel || dsel || amc) && !e_done) begin
        m_busy = 1; m_age = 0;
      end
    end
    check("rf_we", 68'(rf_we), 68'(m_rfwe));
    check("rf_wdata", 68'(rf_wdata), 68'(m_wdata));
    check("imd_q", 68'(imd_q), 68'(m_imd));
    check("perf", 68'(perf), PERF ? 68'(m_perf) : 68'(0));
  endtask

  task automatic idle_inputs();
    valid = 0; kill = 0; msel = 0; dsel = 0; amc = 0; exv = 0; wbr = 1; we = 2'b00;
  endtask

  int to_at;
  int r;

  initial begin
    n_pass = 0; n_checks = 0;
    m_busy = 0; m_age = 0; m_rfwe = 0; m_wdata = '0; m_imd = '0; m_perf = '0;
    rst_n = 0; res = '0; d = '0;
    idle_inputs();
    @(posedge clk);
    #1;
    cycle();
    cycle();
    check("rst_rf_we", 68'(rf_we), 68'(0));
    check("rst_imd", 68'(imd_q), 68'(0));
    rst_n = 1;
    cycle();

    // 1: single-cycle ADD retires next cycle
    valid = 1; exv = 1; res = 32'h5;
    cycle();
    idle_inputs();
    check("t1_first", 68'(o_first), 68'(1));
    check("t1_rf_we", 68'(rf_we), 68'(1));
    check("t1_wdata", 68'(rf_wdata), 68'(32'h5));

    // 2: MUL, EX valid after 3 cycles
    seen_mul = 0; seen_stall = 0;
    valid = 1; msel = 1; res = 32'hDEAD;
    repeat (3) cycle();
    exv = 1;
    cycle();
    idle_inputs();
    check("t2_mul_cycles", 68'(seen_mul), 68'(4));
    check("t2_stall_cycles", 68'(seen_stall), 68'(3));
    check("t2_wdata", 68'(rf_wdata), 68'(32'hDEAD));
    cycle();
    check("t2_we_pulse", 68'(rf_we), 68'(0));

    // 3: DIV killed in cycle 2 together with EX valid
    valid = 1; dsel = 1; res = 32'h1234;
    cycle();
    kill = 1; exv = 1;
    cycle();
    idle_inputs();
    check("t3_div_killed", 68'(o_div), 68'(0));
    check("t3_no_we", 68'(rf_we), 68'(0));
    valid = 1;
    cycle();
    idle_inputs();
    check("t3_idle_first", 68'(o_first), 68'(1));

    // 4: both imd registers written, untouched by a kill
    we = 2'b11; d[1] = 34'h3_0000_0001; d[0] = 34'h2_FFFF_FFFF;
    cycle();
    idle_inputs();
    check("t4_imd", 68'(imd_q), {34'h3_0000_0001, 34'h2_FFFF_FFFF});
    valid = 1; msel = 1; kill = 1;
    cycle();
    idle_inputs();
    check("t4_imd_kill", 68'(imd_q), {34'h3_0000_0001, 34'h2_FFFF_FFFF});

    // 5: watchdog expiry on the 40th MULTI cycle (loop cycle 1 is the issue cycle)
    seen_to = 0; to_at = -1;
    valid = 1; msel = 1;
    for (int i = 1; i <= MAX + 1; i++) begin
      cycle();
      if (o_to && to_at < 0) to_at = i;
    end
    idle_inputs();
    check("t5_to_cycle", 68'(to_at), 68'(MAX + 1));
    check("t5_to_count", 68'(seen_to), 68'(1));
    check("t5_no_we", 68'(rf_we), 68'(0));
    valid = 1;
    cycle();
    idle_inputs();
    check("t5_idle_first", 68'(o_first), 68'(1));

    // Reset while in MULTI drops the pending result
    valid = 1; msel = 1; res = 32'hBEEF;
    cycle();
    cycle();
    rst_n = 0; exv = 1;
    cycle();
    check("rst_mid_no_we", 68'(rf_we), 68'(0));
    rst_n = 1;
    idle_inputs();
    cycle();
    check("rst_mid_no_mul", 68'(o_mul), 68'(0));

    // 6: stall counter: 3 waiting cycles + 2 cycles blocked by writeback
    rst_n = 0;
    cycle();
    rst_n = 1;
    valid = 1; msel = 1; res = 32'hDEAD;
    repeat (3) cycle();
    exv = 1; wbr = 0;
    repeat (2) cycle();
    wbr = 1;
    cycle();
    idle_inputs();
    check("t6_perf", 68'(perf), PERF ? 68'(5) : 68'(0));
    check("t6_wdata", 68'(rf_wdata), 68'(32'hDEAD));

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      valid = ($urandom_range(0, 3) != 0);
      kill  = ($urandom_range(0, 7) == 0);
      r     = $urandom_range(0, 3);
      msel  = (r == 1); dsel = (r == 2); amc = (r == 3);
      exv   = ($urandom_range(0, 2) == 0);
      wbr   = ($urandom_range(0, 3) != 0);
      res   = $urandom;
      we    = 2'($urandom_range(0, 3));
      d[0]  = {2'($urandom_range(0, 3)), 32'($urandom)};
      d[1]  = {2'($urandom_range(0, 3)), 32'($urandom)};
      cycle();
    end
    rst_n = 1;
    idle_inputs();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
